// File: rtl/serial_deser_pkg.sv
// Shared constants for the serial deserializer.
// Optional frame parity is enabled by defining SERIAL_DESER_PARITY_EN.
package serial_deser_pkg;

    localparam int MAX_WIDTH = 32;
    // Sized for the widest legal word, so the counter can also index the parity bit.
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);
    localparam int WCNT_W    = 16;

    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Shift register and bit counter for serial_deser: assembles one frame of serial bits
// in MSB_FIRST order; the trailing parity bit (if any) is counted but not shifted in.
module deser_shift_reg
    import serial_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int FRAME     = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             sin,
    output logic             last_bit,
    output logic [WIDTH-1:0] word_next
);

    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shifted;
    logic             data_bit;

    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {shift_q[WIDTH-2:0], sin};
        end else begin
            shifted = {sin, shift_q[WIDTH-1:1]};
        end
    end

    assign data_bit  = (bit_cnt < CNT_W'(WIDTH));
    assign last_bit  = (bit_cnt == CNT_W'(FRAME - 1));
    // On the parity bit the data is already complete in shift_q.
    assign word_next = data_bit ? shifted : shift_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (accept) begin
            if (data_bit) begin
                shift_q <= shifted;
            end
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with valid/ready handshakes on both sides.
// Define SERIAL_DESER_PARITY_EN to expect a trailing even-parity bit per frame.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_valid,
    output logic              sin_ready,
    output logic [WIDTH-1:0]  pdata,
    output logic              pvalid,
    input  logic              pready,
    output logic              parity_err,
    output logic [WCNT_W-1:0] word_cnt
);

`ifdef SERIAL_DESER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int FRAME = frame_len(WIDTH, PARITY_EN);

    logic             last_bit;
    logic             accept;
    logic             complete;
    logic             deliver;
    logic [WIDTH-1:0] word_next;

    // Only the final bit of a frame can stall: it needs the output register to be free.
    assign sin_ready = !(last_bit && pvalid && !pready);
    assign accept    = sin_valid && sin_ready;
    assign complete  = accept && last_bit;
    assign deliver   = pvalid && pready;

    deser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .FRAME     (FRAME)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .sin       (sin),
        .last_bit  (last_bit),
        .word_next (word_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pdata  <= '0;
            pvalid <= 1'b0;
        end else if (complete) begin
            pdata  <= word_next;
            pvalid <= 1'b1;
        end else if (deliver) begin
            pvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt <= '0;
        end else if (deliver) begin
            word_cnt <= word_cnt + WCNT_W'(1);
        end
    end

`ifdef SERIAL_DESER_PARITY_EN
    // The last accepted bit of a frame is the parity bit itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (complete) begin
            parity_err <= (^word_next) ^ sin;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
